// File: rtl/uart_tx.sv
// uart_tx: UART transmitter, 8 data bits LSB first, optional parity, 1 stop bit.
// Ports:
//   clk    in   system clock, rising edge
//   rst    in   synchronous active-high reset
//   tx_en  in   enables acceptance of new frames (never aborts a running frame)
//   start  in   send request, sampled every clock
//   data   in   byte to send, latched on the accept edge
//   TX     out  serial line, idle high, registered
//   busy   out  frame in progress, registered
//   done   out  one-cycle pulse at frame completion, registered
module uart_tx #(
  parameter int unsigned CLK_FREQ   = 100_000_000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_en,
  input  logic       start,
  input  logic [7:0] data,
  output logic       TX,
  output logic       busy,
  output logic       done
);

  localparam int unsigned BIT_PERIOD = CLK_FREQ / BAUD;
  localparam int unsigned CNT_W      = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_PERIOD - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shreg_q, shreg_d;
  logic             par_q, par_d;
  logic             tx_q, tx_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             bit_end;

  assign bit_end = (cnt_q == CNT_LAST);

  // State and output registers; outputs are loaded with the value for the
  // state being entered so TX changes exactly on bit boundaries.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    par_d   = par_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    // Baud counter runs in every non-idle state and reloads at each bit boundary.
    if (state_q != IDLE) begin
      cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);
    end

    case (state_q)
      IDLE: begin
        cnt_d  = '0;
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (tx_en && start) begin
          state_d = START;
          shreg_d = data;
          par_d   = (^data) ^ (PARITY_ODD != 0);
          tx_d    = 1'b0;
          busy_d  = 1'b1;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          idx_d   = '0;
          tx_d    = shreg_q[0];
          shreg_d = {1'b0, shreg_q[7:1]};
        end
      end
      DATA: begin
        if (bit_end) begin
          idx_d = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
            if (PARITY_EN != 0) begin
              state_d = PARITY;
              tx_d    = par_q;
            end else begin
              state_d = STOP;
              tx_d    = 1'b1;
            end
          end else begin
            tx_d    = shreg_q[0];
            shreg_d = {1'b0, shreg_q[7:1]};
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
          tx_d    = 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          state_d = IDLE;
          tx_d    = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign TX   = tx_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: drives three uart_tx instances (no parity, even parity, odd parity)
// from shared stimulus and compares every cycle against a frame-timeline model.
module tb_uart_tx;

  localparam int unsigned CF = 1000;
  localparam int unsigned BD = 70;
  localparam int unsigned BP = CF / BD;  // 14, truncated

  logic       clk = 1'b0;
  logic       rst, tx_en, start;
  logic [7:0] data;
  logic [2:0] tx_w, busy_w, done_w;

  int total = 0;
  int bad   = 0;
  logic chk_en = 1'b0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    uart_tx #(
      .CLK_FREQ  (CF),
      .BAUD      (BD),
      .PARITY_EN ((g > 0) ? 1 : 0),
      .PARITY_ODD((g == 2) ? 1 : 0)
    ) u_dut (
      .clk  (clk),
      .rst  (rst),
      .tx_en(tx_en),
      .start(start),
      .data (data),
      .TX   (tx_w[g]),
      .busy (busy_w[g]),
      .done (done_w[g])
    );
  end

  // Reference: a frame is a bit list; TX at t cycles after accept is bit t/BP.
  logic        m_act[3];
  int          m_t[3];
  logic [10:0] m_fr[3];
  logic [2:0]  e_tx, e_busy, e_done;
  int          dn[3];

  function automatic logic [10:0] frame(input logic [7:0] d, input int k);
    logic [10:0] f;
    f      = '1;
    f[0]   = 1'b0;
    f[8:1] = d;
    if (k > 0) f[9] = (^d) ^ (k == 2);
    return f;
  endfunction

  function automatic int fbits(input int k);
    return (k > 0) ? 11 : 10;
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        m_act[k] = 1'b0; e_tx[k] = 1'b1; e_busy[k] = 1'b0; e_done[k] = 1'b0;
      end else if (m_act[k]) begin
        m_t[k]++;
        if (m_t[k] == fbits(k) * int'(BP)) begin
          m_act[k] = 1'b0; e_done[k] = 1'b1; e_busy[k] = 1'b0; e_tx[k] = 1'b1;
        end else begin
          e_tx[k] = m_fr[k][m_t[k] / int'(BP)];
        end
      end else begin
        e_done[k] = 1'b0;
        if (tx_en && start) begin
          m_act[k] = 1'b1; m_t[k] = 0; m_fr[k] = frame(data, k);
          e_tx[k] = 1'b0; e_busy[k] = 1'b1;
        end else begin
          e_tx[k] = 1'b1; e_busy[k] = 1'b0;
        end
      end
    end
  end

  task automatic chk(input string tag, input int k, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s[%0d] observed=%h expected=%h t=%0t", tag, k, obs, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, plus DUT done-pulse counters.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (done_w[k] === 1'b1) dn[k]++;
      if (chk_en) begin
        chk("tx", k, 8'(tx_w[k]), 8'(e_tx[k]));
        chk("busy", k, 8'(busy_w[k]), 8'(e_busy[k]));
        chk("done", k, 8'(done_w[k]), 8'(e_done[k]));
      end
    end
  end

  // Called at the negedge right after an accept edge; samples TX of the
  // no-parity instance at mid-bit and returns the received byte and framing bits.
  task automatic rx_frame(output logic [7:0] b, output logic sb, output logic pb);
    logic [9:0] r;
    repeat (BP / 2) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      if (i > 0) repeat (BP) @(negedge clk);
      r[i] = tx_w[0];
    end
    b  = r[8:1];
    sb = r[0];
    pb = r[9];
  endtask

  task automatic send(input logic [7:0] d);
    data  = d;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    data  = 8'($urandom);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((m_act[0] || m_act[1] || m_act[2]) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    total++;
    assert (n < 1000) else begin
      bad++;
      $error("FAIL wait_idle observed=%0d cycles expected<1000", n);
    end
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] rb;
    logic       sb, pb;
    int         d0[3];
    int         n;

    for (int k = 0; k < 3; k++) dn[k] = 0;
    // Reset with a simultaneous start request: reset wins.
    rst = 1'b1; tx_en = 1'b1; start = 1'b1; data = 8'hFF;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("rst_tx", k, 8'(tx_w[k]), 8'd1);
      chk("rst_busy", k, 8'(busy_w[k]), 8'd0);
      chk("rst_done", k, 8'(done_w[k]), 8'd0);
    end
    chk_en = 1'b1;
    rst = 1'b0; start = 1'b0;
    @(negedge clk);

    // start while disabled is ignored.
    tx_en = 1'b0; start = 1'b1;
    repeat (100) @(negedge clk);
    chk("dis_tx", 0, 8'(tx_w), 8'h07);
    chk("dis_busy", 0, 8'(busy_w), 8'h00);
    start = 1'b0; tx_en = 1'b1;
    @(negedge clk);

    // Plain 0x5A frame decoded from the line.
    for (int k = 0; k < 3; k++) d0[k] = dn[k];
    send(8'h5A);
    rx_frame(rb, sb, pb);
    chk("rx5a_start", 0, 8'(sb), 8'd0);
    chk("rx5a_byte", 0, rb, 8'h5A);
    chk("rx5a_stop", 0, 8'(pb), 8'd1);
    wait_idle();
    for (int k = 0; k < 3; k++) chk("one_done", k, 8'(dn[k] - d0[k]), 8'd1);

    // start with 0xFF mid-frame is ignored.
    for (int k = 0; k < 3; k++) d0[k] = dn[k];
    send(8'h5A);
    repeat (3 * BP) @(negedge clk);
    send(8'hFF);
    wait_idle();
    for (int k = 0; k < 3; k++) chk("busy_start_ign", k, 8'(dn[k] - d0[k]), 8'd1);

    // Back-to-back: start held through the done cycle of the no-parity unit.
    data = 8'h5A; start = 1'b1;
    @(negedge clk);
    data = 8'hA5;
    rx_frame(rb, sb, pb);
    chk("b2b_first", 0, rb, 8'h5A);
    n = 0;
    while (done_w[0] !== 1'b1 && n < 4 * int'(BP)) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_done_seen", 0, 8'(done_w[0]), 8'd1);
    @(negedge clk);
    start = 1'b0;
    rx_frame(rb, sb, pb);
    chk("b2b_second", 0, rb, 8'hA5);
    chk("b2b_stop", 0, 8'(pb), 8'd1);
    wait_idle();

    // Dropping tx_en mid-frame does not abort.
    for (int k = 0; k < 3; k++) d0[k] = dn[k];
    send(8'h3C);
    repeat (30) @(negedge clk);
    tx_en = 1'b0;
    wait_idle();
    tx_en = 1'b1;
    for (int k = 0; k < 3; k++) chk("txen_drop_done", k, 8'(dn[k] - d0[k]), 8'd1);

    // Reset mid-frame aborts with no done pulse.
    for (int k = 0; k < 3; k++) d0[k] = dn[k];
    send(8'h5A);
    repeat (50) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_tx", 0, 8'(tx_w), 8'h07);
    chk("abort_busy", 0, 8'(busy_w), 8'h00);
    repeat (200) @(negedge clk);
    for (int k = 0; k < 3; k++) chk("abort_no_done", k, 8'(dn[k] - d0[k]), 8'd0);
    send(8'h3C);
    rx_frame(rb, sb, pb);
    chk("after_rst_byte", 0, rb, 8'h3C);
    wait_idle();

    // Random traffic.
    for (int c = 0; c < 4000; c++) begin
      start = ($urandom_range(0, 7) == 0);
      data  = 8'($urandom);
      tx_en = ($urandom_range(0, 15) != 0);
      rst   = ($urandom_range(0, 599) == 0);
      @(negedge clk);
    end
    rst = 1'b0; start = 1'b0; tx_en = 1'b1;
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
